operand_feeder: RTL and testbench

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/feeder_pkg.sv | 21 ++
 rtl/operand_buf.sv | 46 ++++
 rtl/operand_feeder.sv | 147 ++++++++++++++
 tb/tb_operand_feeder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and defaults for the operand feeder and its buffers.
package feeder_pkg;

  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    FEED,
    WAIT
  } state_t;

  // Row of A presented on lane `lane` during FEED cycle `t`; the lane is
  // active only when the result lies in 0..N-1.
  function automatic int skew_index(input int t, input int lane);
    return t - lane;
  endfunction

endpackage

// File: rtl/operand_buf.sv
// N x N register file: one row-wide write port, N element read ports.
// Read port j always reads column j at its own row address.
module operand_buf
  import feeder_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned DW = DEF_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      we,
  input  logic [$clog2(N)-1:0]      wr_row,
  input  logic [N*DW-1:0]           wr_data,
  input  logic [N*$clog2(N)-1:0]    rd_row,
  output logic [N*DW-1:0]           rd_data
);

  localparam int unsigned RW = $clog2(N);

  logic [DW-1:0] mem [N][N];

  // Storage: reset/clear zeroes everything, otherwise a full row write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int unsigned c = 0; c < N; c++) begin
        mem[wr_row][c] <= wr_data[c*DW +: DW];
      end
    end
  end

  // Element read ports, one per column.
  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      rd_data[j*DW +: DW] = mem[rd_row[j*RW +: RW]][j];
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder for an N x N systolic array: buffers activation (A) and
// weight (W) tiles, preloads W bottom-row-first, then streams A with a
// diagonal skew.
// Optional macro OPERAND_FEEDER_AUTOCLEAR_EN: zero both buffers when a job
// leaves WAIT; otherwise buffer contents persist across jobs.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned DW = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [N*DW-1:0]      wr_data,
  input  logic                 go,
  output logic                 busy,
  output logic                 arr_start,
  input  logic                 arr_ready,
  input  logic                 arr_done,
  output logic [N*DW-1:0]      a_out,
  output logic [N*DW-1:0]      w_out
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned CW = $clog2(3*N);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            done_lat;
  logic            wait_exit;
  logic            clr_bufs;
  logic            we_a;
  logic            we_w;
  logic [N*RW-1:0] a_rd_row;
  logic [N*RW-1:0] w_rd_row;
  logic [N*DW-1:0] a_rd;
  logic [N*DW-1:0] w_rd;
  logic [N-1:0]    lane_hit;

  assign wr_ready = (state == IDLE);
  assign we_a     = wr_valid && wr_ready && !wr_sel;
  assign we_w     = wr_valid && wr_ready &&  wr_sel;

`ifdef OPERAND_FEEDER_AUTOCLEAR_EN
  assign clr_bufs = wait_exit;
`else
  assign clr_bufs = 1'b0;
`endif

  operand_buf #(.N(N), .DW(DW)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_bufs),
    .we      (we_a),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_row  (a_rd_row),
    .rd_data (a_rd)
  );

  operand_buf #(.N(N), .DW(DW)) u_buf_w (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_bufs),
    .we      (we_w),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_row  (w_rd_row),
    .rd_data (w_rd)
  );

  // Next-state logic for the job sequence.
  always_comb begin
    state_next = state;
    wait_exit  = 1'b0;
    unique case (state)
      IDLE: if (go) state_next = ARM;
      ARM:  if (arr_ready) state_next = LOAD;
      LOAD: if (cnt == CW'(N-1)) state_next = FEED;
      FEED: if (cnt == CW'(3*N-2)) state_next = WAIT;
      WAIT: begin
        if (arr_done || done_lat) begin
          state_next = IDLE;
          wait_exit  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, phase counter and early-done latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done_lat <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (state == LOAD || state == FEED) begin
        cnt <= cnt + 1'b1;
      end
      if (wait_exit) begin
        done_lat <= 1'b0;
      end else if (arr_done && (state == ARM || state == LOAD || state == FEED)) begin
        done_lat <= 1'b1;
      end
    end
  end

  // Read addressing: W rows in reverse order, A rows along the skew diagonal.
  always_comb begin
    int r;
    a_rd_row = '0;
    w_rd_row = '0;
    lane_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      r = skew_index(int'(cnt), int'(i));
      lane_hit[i] = (r >= 0) && (r < int'(N));
      a_rd_row[i*RW +: RW] = RW'(r);
      w_rd_row[i*RW +: RW] = RW'(int'(N) - 1 - int'(cnt));
    end
  end

  // Outputs are forced low while rst is held so a mid-job reset is silent at once.
  always_comb begin
    busy      = !rst && (state != IDLE);
    arr_start = !rst && (state == ARM) && arr_ready;
    a_out     = '0;
    w_out     = '0;
    if (!rst && state == LOAD) begin
      w_out = w_rd;
    end
    if (!rst && state == FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (lane_hit[i]) a_out[i*DW +: DW] = a_rd[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: stimulus pushes whole expected jobs
// into a queue, a monitor pops one per arr_start and checks the LOAD and FEED
// streams; control timing is checked against a cycle timeline per job.
module tb_operand_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = $clog2(N);
  localparam int FL = 3*N-1;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sel;
  logic [RW-1:0] wr_row;
  logic [N*DW-1:0] wr_data;
  logic          go;
  logic          busy;
  logic          arr_start;
  logic          arr_ready;
  logic          arr_done;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] w_out;

  operand_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .go        (go),
    .busy      (busy),
    .arr_start (arr_start),
    .arr_ready (arr_ready),
    .arr_done  (arr_done),
    .a_out     (a_out),
    .w_out     (w_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_a [N][N];
  logic [DW-1:0] m_w [N][N];

  typedef struct packed {
    logic [N-1:0][N*DW-1:0]  w;
    logic [FL-1:0][N*DW-1:0] a;
  } job_t;

  job_t exp_q[$];
  job_t cur;
  int   mphase = 0;
  int   midx   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_a[r][c] = '0;
        m_w[r][c] = '0;
      end
  endtask

  task automatic model_write(input bit sel, input int row, input logic [N*DW-1:0] data);
    for (int c = 0; c < N; c++) begin
      if (sel) m_w[row][c] = data[c*DW +: DW];
      else     m_a[row][c] = data[c*DW +: DW];
    end
  endtask

  // Expected job: W rows bottom-first, A element A[t-i][i] on lane i.
  function automatic job_t make_job();
    job_t jb;
    int   r;
    jb = '0;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++)
        jb.w[k][c*DW +: DW] = m_w[N-1-k][c];
    for (int t = 0; t < FL; t++)
      for (int i = 0; i < N; i++) begin
        r = t - i;
        if (r >= 0 && r < N) jb.a[t][i*DW +: DW] = m_a[r][i];
      end
    return jb;
  endfunction

  // Monitor: one expected job per arr_start, then N LOAD and 3N-1 FEED frames.
  always @(negedge clk) begin
    if (rst) begin
      mphase = 0;
      midx   = 0;
    end else begin
      case (mphase)
        0: begin
          chkv("idle_a_out", a_out, '0);
          chkv("idle_w_out", w_out, '0);
          if (arr_start) begin
            if (exp_q.size() == 0) chk1("unexpected_start", arr_start, 1'b0);
            else begin
              cur    = exp_q.pop_front();
              mphase = 1;
              midx   = 0;
            end
          end
        end
        1: begin
          chkv("load_w_out", w_out, cur.w[midx]);
          chkv("load_a_out", a_out, '0);
          midx++;
          if (midx == N) begin mphase = 2; midx = 0; end
        end
        default: begin
          chkv("feed_a_out", a_out, cur.a[midx]);
          chkv("feed_w_out", w_out, '0);
          midx++;
          if (midx == FL) begin mphase = 0; midx = 0; end
        end
      endcase
    end
  end

  task automatic write_row(input bit sel, input int row, input logic [N*DW-1:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_row   = row[RW-1:0];
    wr_data  = data;
    @(negedge clk);
    chk1("write_ready", wr_ready, 1'b1);
    model_write(sel, row, data);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic reset_dut(input int cycles);
    rst = 1'b1; go = 1'b0; wr_valid = 1'b0; arr_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_arr_start", arr_start, 1'b0);
      chkv("rst_a_out", a_out, '0);
      chkv("rst_w_out", w_out, '0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk1("post_rst_wr_ready", wr_ready, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // One job. Cycle c=0 is the cycle after go. arr_ready stays low for rdly
  // cycles, arr_done pulses on cycle dcyc; IDLE returns one cycle after
  // WAIT is entered, or one cycle after a later arr_done.
  task automatic run_job(input int rdly, input int dcyc, input bit feed_poke,
                         input bit go_wr, input bit wsel, input int wrow,
                         input logic [N*DW-1:0] wdata);
    int ls, fs, ws, idle_c;
    ls = rdly + 1;
    fs = ls + N;
    ws = fs + FL;
    idle_c = (dcyc < ws) ? ws + 1 : dcyc + 1;
    go = 1'b1;
    arr_ready = (rdly == 0);
    if (go_wr) begin
      wr_valid = 1'b1; wr_sel = wsel; wr_row = wrow[RW-1:0]; wr_data = wdata;
      model_write(wsel, wrow, wdata);
    end
    exp_q.push_back(make_job());
    @(negedge clk);
    chk1("go_cycle_busy", busy, 1'b0);
    chk1("go_cycle_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    go = 1'b0; wr_valid = 1'b0;
    for (int c = 0; c <= idle_c; c++) begin
      arr_ready = (c >= rdly);
      arr_done  = (c == dcyc);
      if (feed_poke && c == fs + 1) begin
        go = 1'b1; wr_valid = 1'b1; wr_sel = 1'($urandom);
        wr_row = RW'($urandom); wr_data = $urandom;
      end else begin
        go = 1'b0; wr_valid = 1'b0;
      end
      @(negedge clk);
      chk1("job_busy", busy, c < idle_c);
      chk1("job_arr_start", arr_start, c == rdly);
      chk1("job_wr_ready", wr_ready, c >= idle_c);
      @(posedge clk); #1;
    end
    arr_done = 1'b0; go = 1'b0; wr_valid = 1'b0;
`ifdef OPERAND_FEEDER_AUTOCLEAR_EN
    clear_model();
`endif
  endtask

  task automatic rst_mid_job();
    go = 1'b1; arr_ready = 1'b1;
    exp_q.push_back(make_job());
    @(posedge clk); #1;
    go = 1'b0;
    // FEED t=4 falls on c = 1 + N + 4
    for (int c = 0; c < N + 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chkv("rst_feed_a_out", a_out, '0);
    chk1("rst_feed_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chkv("after_rst_a_out", a_out, '0);
    chk1("after_rst_busy", busy, 1'b0);
    chk1("after_rst_wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("after_rst_no_start", arr_start, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nwr;
    logic [N*DW-1:0] d;
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0;
    go = 1'b0; arr_ready = 1'b0; arr_done = 1'b0;
    clear_model();
    reset_dut(3);

    // Buffers must be zero after reset even if written before.
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r, $urandom);
      write_row(1'b1, r, $urandom);
    end
    reset_dut(2);
    run_job(0, 4*N, 1'b0, 1'b0, 1'b0, 0, '0);

    // Identity weights, A[r][c] = 4r + c + 1.
    for (int r = 0; r < N; r++) begin
      d = '0;
      d[r*DW +: DW] = 8'd1;
      write_row(1'b1, r, d);
      for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(4*r + c + 1);
      write_row(1'b0, r, d);
    end
    run_job(0, 4*N, 1'b0, 1'b0, 1'b0, 0, '0);
    // Back-to-back re-run with go alone.
    run_job(0, 4*N + 2, 1'b0, 1'b0, 1'b0, 0, '0);

    // arr_ready held low after go.
    for (int r = 0; r < N; r++) write_row(1'b0, r, $urandom);
    run_job(5, 5 + 4*N, 1'b0, 1'b0, 1'b0, 0, '0);

    // go and write attempt during FEED are ignored; next job proves it.
    for (int r = 0; r < N; r++) write_row(1'b1, r, $urandom);
    run_job(0, 4*N, 1'b1, 1'b0, 1'b0, 0, '0);
    run_job(0, 4*N, 1'b0, 1'b0, 1'b0, 0, '0);

    // arr_done on the last FEED cycle.
    run_job(0, 4*N - 1, 1'b0, 1'b0, 1'b0, 0, '0);

    // Write on the go cycle is used by that job.
    run_job(1, 2, 1'b0, 1'b1, 1'b0, 2, $urandom);

    // Reset mid-job.
    for (int r = 0; r < N; r++) write_row(1'b0, r, $urandom);
    rst_mid_job();

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int rd, ws;
      nwr = $urandom_range(0, 3);
      for (int k = 0; k < nwr; k++)
        write_row(1'($urandom), $urandom_range(0, N-1), $urandom);
      rd = $urandom_range(0, 3);
      ws = rd + 1 + N + FL;
      run_job(rd, $urandom_range(0, ws + 3), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, N-1), $urandom);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
